mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator sitting between the single-cycle datapath's execute stage and the word-organised data memory. It accepts one byte, halfword or word access per request and translates it into word-aligned MemRead/MemWrite cycles. Loads are extracted and sign- or zero-extended. Sub-word stores use read-modify-write. Completion is reported with a one-cycle Done pulse.

## Interface
- DATA_W, 32: data word width; fixed at 32 for MIPS.
- ADDR_W, 32: byte address width.
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- Address  in  ADDR_W  byte address, little-endian lanes.
- StoreData  in  DATA_W  store value, right-justified.
- Size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Busy  out  1  high in every non-IDLE state.
- Done  out  1  one-cycle completion pulse.
- LoadData  out  DATA_W  extended load result; registered and held until the next load completes.
- Error  out  1  misaligned request; valid with Done.
- MemAddress  out  ADDR_W  {latched Address[ADDR_W-1:2], 2'b00}.
- MemWriteData  out  DATA_W  word to memory.
- MemWrite  out  1  memory write enable.
- MemRead  out  1  memory read enable.
- MemReadData  in  DATA_W  memory read data, registered at the edge that samples MemRead; held while MemRead = 0.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, FINISH.
- IDLE, Start = 1: latch ReqWrite, Address, StoreData, Size and Unsigned, then go to ACCESS.
  - Exception: a misaligned request with the trap feature on goes straight to FINISH with Error set.
- ACCESS:
  - Load or sub-word store: MemRead = 1, next state CAPTURE.
  - Word store: MemWrite = 1 with MemWriteData = StoreData, next state FINISH.
- CAPTURE:
  - Load: LoadData <= extracted lane, extended per Unsigned; next state FINISH.
  - Sub-word store: MemWrite = 1 with MemWriteData = MemReadData with the target lane(s) replaced by StoreData[7:0] or StoreData[15:0]; next state FINISH.
- FINISH: Done = 1, Error = latched error flag, next state IDLE.
- Lane selection:
  - Byte uses Address[1:0].
  - Half uses Address[1]: lane 0 = bits 15:0, lane 1 = bits 31:16.
  - Word uses the whole word.
- Memory-side outputs are decoded combinationally from the state and latched request registers. MemRead and MemWrite are never both 1.
- Start while Busy is ignored; no queueing.

## Timing
- Cycle 0 is the edge that samples Start.
- Load: MemRead high in cycle 1, LoadData updated at the end of cycle 2, Done in cycle 3 (latency 3).
- Word store: MemWrite high in cycle 1, Done in cycle 2 (latency 2).
- Sub-word store: MemRead in cycle 1, MemWrite in cycle 2, Done in cycle 3 (latency 3).
- Error: Done and Error in cycle 1; no memory cycle is issued.
- A new Start is accepted on the edge after FINISH, because FINISH always returns to IDLE.
- Back-to-back throughput is one request per latency+1 cycles.
- Reset values:
  - State = IDLE.
  - Busy, Done, Error, MemRead, MemWrite = 0.
  - LoadData, MemAddress, MemWriteData = 0.
- Reset mid-operation: memory enables drop asynchronously, so no partial write is committed at the next edge. The request is discarded and no Done is issued.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with Address[0] = 1, or word with Address[1:0] != 0, sets Error.
  - The memory is untouched.
  - LoadData is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - Offending low bits are ignored: half uses Address[1], word uses lane 0.
  - Error is tied to 0.

## Structure
- Shared package mau_pkg holds:
  - the Size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the lane-width constants.
- Sub-module lane_merge (combinational) performs both load extraction/extension and store merge from Size, the offset and Unsigned. The FSM stays in mem_access_unit.

## Test plan
- Word store then load:
  - Stimulus: store 0xDEADBEEF to 0x10, then load word from 0x10.
  - Required: Done at latency 2 then 3; LoadData = 0xDEADBEEF; MemAddress = 0x10 throughout.
- Byte store merge:
  - Stimulus: word 0x11223344 at 0x20; store byte 0xAB to 0x22.
  - Required: MemRead then MemWrite with 0x11AB3344; a later word load returns 0x11AB3344.
- Load extension:
  - Stimulus: word 0x80F0FF7F at 0x30.
  - Required: signed byte load from 0x31 gives 0xFFFFFFFF; unsigned byte load from 0x33 gives 0x00000080; signed half load from 0x32 gives 0xFFFF80F0.
- Misalignment, trap on:
  - Stimulus: half store to 0x41.
  - Required: Done and Error in cycle 1; MemRead and MemWrite stay 0; word at 0x40 unchanged.
  - Same stimulus without the macro: the half is written to lane 0 and Error = 0.
- Reset during sub-word store:
  - Stimulus: assert Reset_n = 0 in CAPTURE.
  - Required: MemWrite falls immediately; memory word is unchanged; all outputs 0; no Done.
- Start ignored while Busy:
  - Stimulus: pulse Start during ACCESS.
  - Required: it is ignored; exactly one Done is issued.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and constants for the load/store initiator: size codes, FSM states, lane geometry.
package mau_pkg;
  localparam int WORD_W    = 32;
  localparam int LANE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int NUM_LANES = WORD_W / LANE_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, FINISH} state_t;

  // Size 2'b11 aliases word, so only bit 1 decides "word".
  function automatic logic [NUM_LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    if (size[1])      return '1;
    else if (size[0]) return off[1] ? 4'b1100 : 4'b0011;
    else              return 4'b0001 << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size[1])      return off != 2'b00;
    else if (size[0]) return off[0];
    else              return 1'b0;
  endfunction
endpackage

// File: rtl/lane_merge.sv
// Combinational lane logic: load extraction/extension and sub-word store merge into a read word.
module lane_merge
  import mau_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              uns,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] sdata,
  output logic [WORD_W-1:0] ldata,
  output logic [WORD_W-1:0] wdata
);
  logic [NUM_LANES-1:0] be;
  logic [WORD_W-1:0]    srep;
  logic [LANE_W-1:0]    bsel;
  logic [HALF_W-1:0]    hsel;

  assign be = lane_en(size, off);

  always_comb begin
    if (size[1])      srep = sdata;
    else if (size[0]) srep = {2{sdata[HALF_W-1:0]}};
    else              srep = {NUM_LANES{sdata[LANE_W-1:0]}};
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wdata[g*LANE_W +: LANE_W] = be[g] ? srep[g*LANE_W +: LANE_W] : rdata[g*LANE_W +: LANE_W];
  end

  assign bsel = rdata[off*LANE_W +: LANE_W];
  assign hsel = rdata[off[1]*HALF_W +: HALF_W];

  always_comb begin
    if (size[1])      ldata = rdata;
    else if (size[0]) ldata = {{(WORD_W-HALF_W){~uns & hsel[HALF_W-1]}}, hsel};
    else              ldata = {{(WORD_W-LANE_W){~uns & bsel[LANE_W-1]}}, bsel};
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word requests -> word-aligned memory cycles, RMW for sub-word stores.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word requests complete at once with Error.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] LoadData,
  output logic              Error,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sdata;
    logic [1:0]        size;
    logic              uns;
    logic              err;
  } req_t;

  state_t            state;
  req_t              req;
  logic              mis;
  logic              wstore;
  logic [DATA_W-1:0] ldata, mdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(Size, Address[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign wstore = req.wr & req.size[1];

  lane_merge u_lane (
    .size  (req.size),
    .off   (req.addr[1:0]),
    .uns   (req.uns),
    .rdata (MemReadData),
    .sdata (req.sdata),
    .ldata (ldata),
    .wdata (mdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      req      <= '0;
      LoadData <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          req   <= '{wr: ReqWrite, addr: Address, sdata: StoreData, size: Size, uns: Unsigned, err: mis};
          state <= mis ? FINISH : ACCESS;
        end
        ACCESS:  state <= wstore ? FINISH : CAPTURE;
        CAPTURE: begin
          if (!req.wr) LoadData <= ldata;
          state <= FINISH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is decoded from state so enables drop the instant reset asserts.
  assign Busy         = state != IDLE;
  assign Done         = state == FINISH;
  assign Error        = Done & req.err;
  assign MemAddress   = {req.addr[ADDR_W-1:2], 2'b00};
  assign MemRead      = (state == ACCESS) & ~wstore;
  assign MemWrite     = ((state == ACCESS) & wstore) | ((state == CAPTURE) & req.wr);
  assign MemWriteData = !MemWrite ? '0 : (state == ACCESS) ? req.sdata : mdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table vectors, reset/busy corner sequences, random traffic vs a word-array model.
module tb_mem_access_unit;
  logic        Clock = 0;
  logic        Reset_n = 0;
  logic        Start = 0, ReqWrite = 0, Unsigned = 0;
  logic [31:0] Address = 0, StoreData = 0;
  logic [1:0]  Size = 0;
  logic        Busy, Done, Error, MemWrite, MemRead;
  logic [31:0] LoadData, MemAddress, MemWriteData;
  logic [31:0] MemReadData = 0;

  logic [31:0] ram [64] = '{default: 0};
  logic [31:0] ref_mem [64] = '{default: 0};
  logic [31:0] ref_ld = 0;
  int total = 0, bad = 0;

  mem_access_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .ReqWrite(ReqWrite), .Address(Address),
    .StoreData(StoreData), .Size(Size), .Unsigned(Unsigned), .Busy(Busy), .Done(Done),
    .LoadData(LoadData), .Error(Error), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemRead)  MemReadData <= ram[MemAddress[7:2]];
    if (MemWrite) ram[MemAddress[7:2]] <= MemWriteData;
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] sd;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] eld;
    logic        eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: memory as words, access = byte window of nb bytes at offset off.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz,
                       input logic u, output logic [31:0] eld, output logic eerr);
    int idx, nb, off;
    logic [31:0] mask, v;
    idx = int'(a[7:2]);
    if (sz[1])      begin nb = 4; off = 0; end
    else if (sz[0]) begin nb = 2; off = a[1] ? 2 : 0; end
    else            begin nb = 1; off = int'(a[1:0]); end
    eerr = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 0)) eerr = 1;
`endif
    if (!eerr) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 1);
      if (w) ref_mem[idx] = (ref_mem[idx] & ~(mask << (8*off))) | ((sd & mask) << (8*off));
      else begin
        v = (ref_mem[idx] >> (8*off)) & mask;
        if (!u && nb < 4 && v[8*nb-1]) v = v | ~mask;
        ref_ld = v;
      end
    end
    eld = ref_ld;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz,
                        input logic u, output int lat, output logic [31:0] ld, output logic er,
                        output int nr, output int nw, output logic order_ok, output logic addr_ok);
    @(negedge Clock);
    Start = 1; ReqWrite = w; Address = a; StoreData = sd; Size = sz; Unsigned = u;
    @(posedge Clock); #1 Start = 0;
    lat = 0; nr = 0; nw = 0; order_ok = 1; addr_ok = 1; ld = 'x; er = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      if (MemRead) begin nr++; if (nw > 0) order_ok = 0; end
      if (MemWrite) nw++;
      if (MemRead && MemWrite) order_ok = 0;
      if (Busy && MemAddress != {a[31:2], 2'b00}) addr_ok = 0;
      if (Done) begin lat = k; ld = LoadData; er = Error; break; end
    end
  endtask

  task automatic run(input string nm, input logic w, input logic [31:0] a, input logic [31:0] sd,
                     input logic [1:0] sz, input logic u, input logic [31:0] eld, input logic eerr);
    int lat, nr, nw, elat, enr, enw;
    logic [31:0] ld;
    logic er, ook, aok;
    do_req(w, a, sd, sz, u, lat, ld, er, nr, nw, ook, aok);
    if (eerr)       begin elat = 1; enr = 0; enw = 0; end
    else if (!w)    begin elat = 3; enr = 1; enw = 0; end
    else if (sz[1]) begin elat = 2; enr = 0; enw = 1; end
    else            begin elat = 3; enr = 1; enw = 1; end
    chk({nm, ".latency"}, lat, elat);
    if (lat != 0) begin
      chk({nm, ".loaddata"}, ld, eld);
      chk({nm, ".error"}, {31'b0, er}, {31'b0, eerr});
    end
    chk({nm, ".reads"}, nr, enr);
    chk({nm, ".writes"}, nw, enw);
    chk({nm, ".order"}, {31'b0, ook}, 32'd1);
    chk({nm, ".memaddr"}, {31'b0, aok}, 32'd1);
  endtask

  vec_t tbl [14];

  initial begin
    logic [31:0] eld;
    logic eerr;
    int dones, writes;

    tbl[0]  = '{1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h00000000, 0};
    tbl[1]  = '{0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 32'h20, 32'h11223344, 2'b10, 0, 32'hDEADBEEF, 0};
    tbl[3]  = '{1, 32'h22, 32'h000000AB, 2'b00, 0, 32'hDEADBEEF, 0};
    tbl[4]  = '{0, 32'h20, 32'h0,        2'b10, 0, 32'h11AB3344, 0};
    tbl[5]  = '{1, 32'h30, 32'h80F0FF7F, 2'b10, 0, 32'h11AB3344, 0};
    tbl[6]  = '{0, 32'h31, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 0};
    tbl[7]  = '{0, 32'h33, 32'h0,        2'b00, 1, 32'h00000080, 0};
    tbl[8]  = '{0, 32'h32, 32'h0,        2'b01, 0, 32'hFFFF80F0, 0};
    tbl[9]  = '{1, 32'h40, 32'hCAFEF00D, 2'b10, 0, 32'hFFFF80F0, 0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[10] = '{1, 32'h41, 32'h00001234, 2'b01, 0, 32'hFFFF80F0, 1};
    tbl[11] = '{0, 32'h40, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0};
`else
    tbl[10] = '{1, 32'h41, 32'h00001234, 2'b01, 0, 32'hFFFF80F0, 0};
    tbl[11] = '{0, 32'h40, 32'h0,        2'b10, 0, 32'hCAFE1234, 0};
`endif
    tbl[12] = '{0, 32'h30, 32'h0,        2'b11, 0, 32'h80F0FF7F, 0};
    tbl[13] = '{0, 32'h30, 32'h0,        2'b01, 1, 32'h0000FF7F, 0};

    // reset state
    #2;
    chk("rst.busy", {31'b0, Busy}, 0);
    chk("rst.done", {31'b0, Done}, 0);
    chk("rst.error", {31'b0, Error}, 0);
    chk("rst.memread", {31'b0, MemRead}, 0);
    chk("rst.memwrite", {31'b0, MemWrite}, 0);
    chk("rst.loaddata", LoadData, 0);
    chk("rst.memaddr", MemAddress, 0);
    chk("rst.memwdata", MemWriteData, 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1;

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].sd, tbl[i].sz, tbl[i].u, eld, eerr);
      run($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].sd, tbl[i].sz, tbl[i].u, tbl[i].eld, tbl[i].eerr);
    end

    // reset while a byte store sits in CAPTURE
    model(1, 32'h50, 32'h55667788, 2'b10, 0, eld, eerr);
    run("pre50", 1, 32'h50, 32'h55667788, 2'b10, 0, eld, eerr);
    @(negedge Clock);
    Start = 1; ReqWrite = 1; Address = 32'h51; StoreData = 32'h99; Size = 2'b00; Unsigned = 0;
    @(posedge Clock); #1 Start = 0;
    @(negedge Clock);
    @(negedge Clock);
    chk("rstmid.pre_memwrite", {31'b0, MemWrite}, 1);
    #1 Reset_n = 0;
    #1;
    chk("rstmid.memwrite", {31'b0, MemWrite}, 0);
    chk("rstmid.memread", {31'b0, MemRead}, 0);
    chk("rstmid.busy", {31'b0, Busy}, 0);
    chk("rstmid.done", {31'b0, Done}, 0);
    chk("rstmid.loaddata", LoadData, 0);
    chk("rstmid.memaddr", MemAddress, 0);
    chk("rstmid.memwdata", MemWriteData, 0);
    ref_ld = 0;
    @(negedge Clock);
    Reset_n = 1;
    dones = 0;
    repeat (6) begin @(negedge Clock); if (Done) dones++; end
    chk("rstmid.no_done", dones, 0);
    chk("rstmid.mem", ram[20], 32'h55667788);

    // Start pulsed during ACCESS is dropped
    @(negedge Clock);
    Start = 1; ReqWrite = 0; Address = 32'h10; Size = 2'b10; Unsigned = 0;
    @(posedge Clock); #1 Start = 0;
    @(negedge Clock);
    chk("busy.access", {31'b0, Busy}, 1);
    Start = 1; ReqWrite = 1; Address = 32'h60; StoreData = 32'hFFFFFFFF; Size = 2'b10;
    @(posedge Clock); #1 Start = 0;
    dones = 0; writes = 0;
    repeat (8) begin @(negedge Clock); if (Done) dones++; if (MemWrite) writes++; end
    model(0, 32'h10, 32'h0, 2'b10, 0, eld, eerr);
    chk("busy.dones", dones, 1);
    chk("busy.writes", writes, 0);
    chk("busy.loaddata", LoadData, eld);

    for (int i = 0; i < 60; i++) begin
      logic w, u;
      logic [31:0] a, sd;
      logic [1:0] sz;
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255); sd = $urandom; sz = 2'($urandom_range(0, 3));
      model(w, a, sd, sz, u, eld, eerr);
      run($sformatf("rnd%0d", i), w, a, sd, sz, u, eld, eerr);
    end

    writes = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) writes++;
    chk("final.mem_words_differing", writes, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
